// File: rtl/dmem_debug_writer.sv
// rtl/dmem_debug_writer.sv - switch/button driven single-word data-memory writer
//
// Entry sequence: next loads the address, next captures the low data half-word,
// next captures the high half-word and issues the write, which then waits for
// dm_ready. The abort button cancels entry before the write is issued.
//
// Build option: define DMEM_DEBUG_DEBOUNCE_EN to debounce both buttons
// (a level must be stable for 2^DB_W clocks). Otherwise the buttons are only
// synchronised and edge-detected.
//
// Ports (dmem_debug_writer):
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   sw_i       in   16  switch value: address (bit 15 = auto-increment) or data half-word
//   btn_next   in   raw button, advances the entry sequence
//   btn_abort  in   raw button, cancels entry in LO/HI
//   dm_ready   in   memory accepts the write this cycle
//   dm_we      out  registered write request
//   dm_addr    out  ADDR_W  write address
//   dm_wdata   out  32  write data
//   state_o    out  3   FSM state (IDLE=0, LO=1, HI=2, WRITE=3)
//   wr_count   out  8   completed writes, wraps
//
// Ports (dmem_debug_btn_cond):
//   clk, reset  as above
//   btn_i       in   raw button
//   pulse_o     out  one-clock pulse per accepted press

module dmem_debug_btn_cond #(
  parameter int DB_W = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic lvl_q;

`ifdef DMEM_DEBUG_DEBOUNCE_EN
  logic            lvl_prev_q;
  logic [DB_W-1:0] cnt_q;

  // cnt_q counts consecutive samples that disagree with the accepted level;
  // the 2^DB_W-th such sample replaces the accepted level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= btn_i;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl_q;
      if (sync2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == {DB_W{1'b1}}) begin
        lvl_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + {{(DB_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign pulse_o = lvl_q & ~lvl_prev_q;
`else
  // lvl_q is simply the previous synchronised sample here.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      lvl_q   <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~lvl_q;

  // DB_W only sizes the debounce counter, absent in this build.
  logic unused_db_w;
  assign unused_db_w = ^DB_W;
`endif

endmodule

module dmem_debug_writer #(
  parameter int DB_W   = 20,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       sw_i,
  input  logic              btn_next,
  input  logic              btn_abort,
  input  logic              dm_ready,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [2:0]        state_o,
  output logic [7:0]        wr_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LO    = 3'd1,
    HI    = 3'd2,
    WRITE = 3'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              next_pulse;
  logic              abort_pulse;

  dmem_debug_btn_cond #(.DB_W(DB_W)) u_next_cond (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_next),
    .pulse_o (next_pulse)
  );

  dmem_debug_btn_cond #(.DB_W(DB_W)) u_abort_cond (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_abort),
    .pulse_o (abort_pulse)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      last_addr_q <= '1;   // all-ones so the first auto-increment lands on 0
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (next_pulse) begin
          addr_d  = sw_i[15] ? last_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1}
                             : sw_i[ADDR_W-1:0];
          state_d = LO;
        end
      end
      LO: begin
        // Abort has priority over a simultaneous next.
        if (abort_pulse) begin
          state_d = IDLE;
        end else if (next_pulse) begin
          wdata_d[15:0] = sw_i;
          state_d       = HI;
        end
      end
      HI: begin
        if (abort_pulse) begin
          state_d = IDLE;
        end else if (next_pulse) begin
          wdata_d[31:16] = sw_i;
          we_d           = 1'b1;
          state_d        = WRITE;
        end
      end
      WRITE: begin
        // Buttons are ignored; only the memory handshake leaves this state.
        if (we_q && dm_ready) begin
          we_d        = 1'b0;
          cnt_d       = cnt_q + 8'd1;
          last_addr_d = addr_q;
          state_d     = IDLE;
        end
      end
      default: begin
        we_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign dm_we    = we_q;
  assign dm_addr  = addr_q;
  assign dm_wdata = wdata_q;
  assign state_o  = state_q;
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_dmem_debug_writer.sv
// tb/tb_dmem_debug_writer.sv - directed self-checking bench for dmem_debug_writer

module tb_dmem_debug_writer;

`ifdef DMEM_DEBUG_DEBOUNCE_EN
  localparam int TB_DB_W = 4;
`else
  localparam int TB_DB_W = 20;
`endif

  localparam int OP_NEXT  = 0;
  localparam int OP_ABORT = 1;
  localparam int OP_BOTH  = 2;
  localparam int OP_ACK   = 3;

  typedef struct {
    int          op;
    logic [15:0] sw;
    logic [2:0]  st;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  cnt;
    logic        we;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw_i;
  logic        btn_next;
  logic        btn_abort;
  logic        dm_ready;
  logic        dm_we;
  logic [5:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  state_o;
  logic [7:0]  wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[15];

  dmem_debug_writer #(.DB_W(TB_DB_W), .ADDR_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_i      (sw_i),
    .btn_next  (btn_next),
    .btn_abort (btn_abort),
    .dm_ready  (dm_ready),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .state_o   (state_o),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic [5:0] addr,
                           input logic [31:0] wdata, input logic [7:0] cnt, input logic we);
    check({tag, " state"}, {29'd0, state_o}, {29'd0, st});
    check({tag, " addr"},  {26'd0, dm_addr}, {26'd0, addr});
    check({tag, " wdata"}, dm_wdata, wdata);
    check({tag, " count"}, {24'd0, wr_count}, {24'd0, cnt});
    check({tag, " we"},    {31'd0, dm_we}, {31'd0, we});
  endtask

  // Called at a negedge; returns at a negedge with buttons released.
  task automatic press(input logic n, input logic a, input logic [15:0] s);
    sw_i      = s;
    btn_next  = n;
    btn_abort = a;
    repeat (4) @(negedge clk);
    btn_next  = 1'b0;
    btn_abort = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ack();
    dm_ready = 1'b1;
    @(negedge clk);
    dm_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    sw_i      = 16'h0000;
    btn_next  = 1'b0;
    btn_abort = 1'b0;
    dm_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset", 3'd0, 6'd0, 32'h0, 8'd0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

`ifdef DMEM_DEBUG_DEBOUNCE_EN
    // Three 15-clock glitches must never be accepted.
    for (int g = 0; g < 3; g++) begin
      sw_i     = 16'h0007;
      btn_next = 1'b1;
      repeat (15) @(negedge clk);
      btn_next = 1'b0;
      repeat (4) @(negedge clk);
      check($sformatf("glitch%0d state", g), {29'd0, state_o}, 32'd0);
    end
    // A long press gives exactly one transition, release gives none.
    btn_next = 1'b1;
    repeat (30) @(negedge clk);
    check("long press state", {29'd0, state_o}, 32'd1);
    check("long press addr", {26'd0, dm_addr}, 32'd7);
    btn_next = 1'b0;
    repeat (30) @(negedge clk);
    check("release state", {29'd0, state_o}, 32'd1);
`else
    vecs[0]  = '{OP_NEXT,  16'h0005, 3'd1, 6'd5,  32'h00000000, 8'd0, 1'b0};
    vecs[1]  = '{OP_NEXT,  16'hBEEF, 3'd2, 6'd5,  32'h0000BEEF, 8'd0, 1'b0};
    vecs[2]  = '{OP_NEXT,  16'hDEAD, 3'd3, 6'd5,  32'hDEADBEEF, 8'd0, 1'b1};
    vecs[3]  = '{OP_ACK,   16'h0000, 3'd0, 6'd5,  32'hDEADBEEF, 8'd1, 1'b0};
    vecs[4]  = '{OP_NEXT,  16'h8000, 3'd1, 6'd6,  32'hDEADBEEF, 8'd1, 1'b0};
    vecs[5]  = '{OP_ABORT, 16'h0000, 3'd0, 6'd6,  32'hDEADBEEF, 8'd1, 1'b0};
    vecs[6]  = '{OP_NEXT,  16'h803F, 3'd1, 6'd6,  32'hDEADBEEF, 8'd1, 1'b0};
    vecs[7]  = '{OP_NEXT,  16'h1234, 3'd2, 6'd6,  32'hDEAD1234, 8'd1, 1'b0};
    vecs[8]  = '{OP_BOTH,  16'h5678, 3'd0, 6'd6,  32'hDEAD1234, 8'd1, 1'b0};
    vecs[9]  = '{OP_NEXT,  16'h00FF, 3'd1, 6'd63, 32'hDEAD1234, 8'd1, 1'b0};
    vecs[10] = '{OP_NEXT,  16'hCAFE, 3'd2, 6'd63, 32'hDEADCAFE, 8'd1, 1'b0};
    vecs[11] = '{OP_NEXT,  16'h0123, 3'd3, 6'd63, 32'h0123CAFE, 8'd1, 1'b1};
    vecs[12] = '{OP_ACK,   16'h0000, 3'd0, 6'd63, 32'h0123CAFE, 8'd2, 1'b0};
    vecs[13] = '{OP_NEXT,  16'h8000, 3'd1, 6'd0,  32'h0123CAFE, 8'd2, 1'b0};
    vecs[14] = '{OP_ABORT, 16'h0000, 3'd0, 6'd0,  32'h0123CAFE, 8'd2, 1'b0};

    for (int i = 0; i < 15; i++) begin
      case (vecs[i].op)
        OP_NEXT:  press(1'b1, 1'b0, vecs[i].sw);
        OP_ABORT: press(1'b0, 1'b1, vecs[i].sw);
        OP_BOTH:  press(1'b1, 1'b1, vecs[i].sw);
        default:  ack();
      endcase
      check_all($sformatf("v%0d", i), vecs[i].st, vecs[i].addr, vecs[i].wdata,
                vecs[i].cnt, vecs[i].we);
    end

    // Stalled write: abort and next during WRITE are ignored.
    press(1'b1, 1'b0, 16'h0009);
    press(1'b1, 1'b0, 16'h1111);
    press(1'b1, 1'b0, 16'h2222);
    for (int c = 0; c < 10; c++) begin
      if (c == 1) btn_abort = 1'b1;
      if (c == 4) btn_abort = 1'b0;
      if (c == 5) btn_next  = 1'b1;
      if (c == 8) btn_next  = 1'b0;
      check_all($sformatf("stall%0d", c), 3'd3, 6'd9, 32'h22221111, 8'd2, 1'b1);
      @(negedge clk);
    end
    ack();
    check_all("stall done", 3'd0, 6'd9, 32'h22221111, 8'd3, 1'b0);
    repeat (3) @(negedge clk);
    check("stall settle state", {29'd0, state_o}, 32'd0);

    // Reset in the middle of a pending write.
    press(1'b1, 1'b0, 16'h0001);
    press(1'b1, 1'b0, 16'h3333);
    press(1'b1, 1'b0, 16'h4444);
    check_all("pre-reset", 3'd3, 6'd1, 32'h44443333, 8'd3, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all("mid-write reset", 3'd0, 6'd0, 32'h0, 8'd0, 1'b0);

    // Reaction on the third edge; auto-increment right after reset gives 0.
    sw_i     = 16'h8000;
    btn_next = 1'b1;
    @(negedge clk);
    check("edge1 state", {29'd0, state_o}, 32'd0);
    @(negedge clk);
    check("edge2 state", {29'd0, state_o}, 32'd0);
    @(negedge clk);
    check("edge3 state", {29'd0, state_o}, 32'd1);
    check("edge3 addr", {26'd0, dm_addr}, 32'd0);
    btn_next = 1'b0;
    repeat (3) @(negedge clk);
    press(1'b0, 1'b1, 16'h0000);
    check_all("final abort", 3'd0, 6'd0, 32'h0, 8'd0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
